// File: rtl/nibble_packer.sv
// nibble_packer: serial-to-parallel packer. Sixteen 4-bit nibbles are taken
// over a valid/ready handshake and packed MSB-first into a 64-bit word. The word
// is held with word_valid until word_ack, then cleared for the next fill.
//
// Ports:
//   CLK        system clock, rising edge
//   reset      synchronous active-high reset
//   nib_in     nibble to pack
//   nib_valid  nib_in holds a nibble this cycle
//   nib_ready  packer accepts a nibble this cycle (FILL)
//   word_out   packed word, first nibble in [63:60], sixteenth in [3:0]
//   word_valid word_out complete and stable (HOLD)
//   word_ack   consumer done with word_out; honoured only in HOLD
//   count      nibbles accepted into the current word (0..15)
//   checksum   sum of accepted nibbles
//
// Optional feature: define NIBBLE_PACKER_CHECKSUM_EN to build the running
// checksum accumulator; otherwise checksum is tied to 8'h00.

module nibble_packer (
    input  logic        CLK,
    input  logic        reset,
    input  logic [3:0]  nib_in,
    input  logic        nib_valid,
    output logic        nib_ready,
    output logic [63:0] word_out,
    output logic        word_valid,
    input  logic        word_ack,
    output logic [3:0]  count,
    output logic [7:0]  checksum
);

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned SUM_W   = 8;
    localparam int unsigned SLOT_IW = 6;

    localparam logic [NIB_W-1:0] LAST_SLOT = NIB_W'(15);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic               accept_c;
    logic               clear_c;
    logic [SLOT_IW-1:0] slot_lsb_c;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        clear_c    = 1'b0;
        case (state)
            FILL: begin
                if (nib_valid) begin
                    accept_c = 1'b1;
                    if (count == LAST_SLOT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (word_ack) begin
                    clear_c    = 1'b1;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Handshake flags track the state register one-for-one, so they are
    // registered from state_next and carry no path from nib_valid/word_ack.
    always_ff @(posedge CLK) begin
        if (reset) begin
            nib_ready  <= 1'b1;
            word_valid <= 1'b0;
        end else begin
            nib_ready  <= (state_next == FILL);
            word_valid <= (state_next == HOLD);
        end
    end

    // Slot k occupies bits [63-4k -: 4]; its LSB is 4*(15-k), and 15-k == ~k.
    assign slot_lsb_c = {~count, 2'b00};

    // Word assembly and nibble counter
    always_ff @(posedge CLK) begin
        if (reset) begin
            word_out <= WORD_W'(0);
            count    <= NIB_W'(0);
        end else if (clear_c) begin
            word_out <= WORD_W'(0);
        end else if (accept_c) begin
            word_out[slot_lsb_c +: NIB_W] <= nib_in;
            count                         <= count + NIB_W'(1);
        end
    end

`ifdef NIBBLE_PACKER_CHECKSUM_EN
    // Running checksum; at most 16*15 = 240, so 8 bits never overflow.
    always_ff @(posedge CLK) begin
        if (reset || clear_c) begin
            checksum <= SUM_W'(0);
        end else if (accept_c) begin
            checksum <= checksum + SUM_W'(nib_in);
        end
    end
`else
    assign checksum = SUM_W'(0);
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: self-checking bench for nibble_packer. A cycle model of the
// packer checks the handshake, count, word and checksum after every edge, and a
// scoreboard queue of expected complete words is popped whenever word_valid rises.

module tb_nibble_packer;

    logic        CLK;
    logic        reset;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready;
    logic [63:0] word_out;
    logic        word_valid;
    logic        word_ack;
    logic [3:0]  count;
    logic [7:0]  checksum;

    nibble_packer dut (
        .CLK        (CLK),
        .reset      (reset),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ack   (word_ack),
        .count      (count),
        .checksum   (checksum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected complete words: {checksum, word}
    logic [71:0] sb_q[$];

    // Reference model state
    logic [63:0] m_word;
    logic [3:0]  m_count;
    logic [7:0]  m_sum;
    logic        m_hold;
    logic        prev_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_csum(input logic [7:0] s);
`ifdef NIBBLE_PACKER_CHECKSUM_EN
        return s;
`else
        return 8'h00;
`endif
    endfunction

    task automatic push_word(input logic [63:0] w, input logic [7:0] s);
        sb_q.push_back({exp_csum(s), w});
    endtask

    // One clock: update the model from the inputs sampled at the edge, then
    // compare outputs 1 time unit later.
    task automatic step();
        logic [71:0] e;
        int idx;
        @(posedge CLK);
        if (reset) begin
            m_word  = 64'h0;
            m_count = 4'h0;
            m_sum   = 8'h0;
            m_hold  = 1'b0;
        end else if (!m_hold) begin
            if (nib_valid) begin
                idx = 63 - 4 * int'(m_count);
                m_word[idx -: 4] = nib_in;
                m_sum = m_sum + {4'h0, nib_in};
                if (m_count == 4'hF) m_hold = 1'b1;
                m_count = m_count + 4'h1;
            end
        end else if (word_ack) begin
            m_word = 64'h0;
            m_sum  = 8'h0;
            m_hold = 1'b0;
        end
        #1;
        check("nib_ready", 64'(nib_ready), 64'(!m_hold));
        check("word_valid", 64'(word_valid), 64'(m_hold));
        check("count", 64'(count), 64'(m_count));
        check("word_out", word_out, m_word);
        check("checksum", 64'(checksum), 64'(exp_csum(m_sum)));
        if (word_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_word", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("sb_word", word_out, e[63:0]);
                check("sb_csum", 64'(checksum), 64'(e[71:64]));
            end
        end
        prev_valid = word_valid;
    endtask

    task automatic send(input logic [3:0] n);
        nib_valid = 1'b1;
        nib_in    = n;
        step();
    endtask

    task automatic idle(input int cycles);
        nib_valid = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic ack_pulse();
        nib_valid = 1'b0;
        word_ack  = 1'b1;
        step();
        word_ack  = 1'b0;
    endtask

    initial begin
        m_word = 64'h0; m_count = 4'h0; m_sum = 8'h0; m_hold = 1'b0;
        prev_valid = 1'b0;
        reset = 1'b1; nib_in = 4'h0; nib_valid = 1'b0; word_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        idle(1);

        // Ascending nibbles on consecutive cycles
        push_word(64'h0123456789ABCDEF, 8'h78);
        for (int i = 0; i < 16; i++) send(4'(i));
        check("asc_valid", 64'(word_valid), 64'(1));
        check("asc_count", 64'(count), 64'(0));
        ack_pulse();

        // Sixteen 0xF with nib_valid toggling: word completes after 31 cycles
        push_word(64'hFFFFFFFFFFFFFFFF, 8'hF0);
        nib_in = 4'hF;
        for (int i = 0; i < 31; i++) begin
            nib_valid = (i % 2 == 0);
            step();
            if (i == 29) check("gap_not_yet", 64'(word_valid), 64'(0));
        end
        check("gap_valid31", 64'(word_valid), 64'(1));
        ack_pulse();

        // Hold with nibbles offered: must not be consumed
        push_word(64'h3333333333333333, 8'h30);
        for (int i = 0; i < 16; i++) send(4'h3);
        nib_valid = 1'b1; nib_in = 4'h5;
        for (int i = 0; i < 10; i++) step();
        check("hold_word", word_out, 64'h3333333333333333);
        word_ack = 1'b1;
        step();
        word_ack = 1'b0;
        check("ack_valid", 64'(word_valid), 64'(0));
        check("ack_clear", word_out, 64'h0);
        step();
        check("first_after_ack", word_out, 64'h5000000000000000);
        push_word(64'h5555555555555555, 8'h50);
        for (int i = 0; i < 15; i++) send(4'h5);
        ack_pulse();

        // Reset mid-fill discards the partial word
        for (int i = 0; i < 5; i++) send(4'hA);
        nib_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_count", 64'(count), 64'(0));
        check("rst_word", word_out, 64'h0);
        check("rst_csum", 64'(checksum), 64'(0));
        check("rst_ready", 64'(nib_ready), 64'(1));
        push_word(64'h1111111111111111, 8'h10);
        for (int i = 0; i < 16; i++) send(4'h1);
        ack_pulse();

        // word_ack ignored in FILL, then held high: one ack per word
        word_ack = 1'b1;
        for (int i = 0; i < 3; i++) send(4'h7);
        check("fill_ack_count", 64'(count), 64'(3));
        push_word(64'h7777777777777777, 8'h70);
        for (int i = 0; i < 13; i++) send(4'h7);
        check("held_ack_valid", 64'(word_valid), 64'(1));
        nib_valid = 1'b0;
        step();
        check("held_ack_done", 64'(word_valid), 64'(0));
        push_word(64'h2222222222222222, 8'h20);
        for (int i = 0; i < 15; i++) send(4'h2);
        check("held_ack_partial", 64'(count), 64'(15));
        send(4'h2);
        check("held_ack_full", 64'(word_valid), 64'(1));
        nib_valid = 1'b0;
        step();
        word_ack = 1'b0;
        idle(2);

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
